// File: rtl/mii_rx_framer.sv
// mii_rx_framer: receive-side framer between PHY capture logic and the MAC/packet buffer.
// Accepts a nibble (IN_W=4, MII) or byte (IN_W=8, GMII / post-DDR RGMII) stream. It checks
// the preamble/SFD, assembles bytes, runs CRC-32 and the length checks, and can hold back
// the FCS. Output is a byte stream plus one status strobe per frame.
//
// Parameters:
//   IN_W      4 = nibble mode, 8 = byte mode (no other values are supported)
//   MIN_LEN   minimum legal frame length in bytes (DA..FCS)
//   MAX_LEN   maximum legal frame length; bytes past this are counted but not emitted
//   CHECK_FCS 1 = flag CRC residue mismatch, 0 = never flag FCS errors
//   STRIP_FCS 1 = last four frame bytes are not emitted
//
// Ports:
//   clk        receive clock, everything sampled on the rising edge
//   reset      synchronous active-high reset
//   mii_en     RX_DV
//   mii_er     RX_ER, only meaningful while mii_en=1
//   mii_d      receive data, bit 0 first on the wire
//   rdy        one-cycle strobe, d holds a frame byte
//   d          frame byte (DA onward)
//   last       with rdy: final emitted byte of the frame
//   done       one-cycle frame status strobe
//   error      with done: frame bad
//   err_code   with done: 0 ok, 1 preamble/SFD, 2 runt, 3 giant, 4 FCS, 5 mii_er, 6 dribble
//   frame_len  with done: bytes after SFD including FCS, saturating at 16'hFFFF
module mii_rx_framer #(
  parameter int unsigned IN_W      = 4,
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 1518,
  parameter bit          CHECK_FCS = 1'b1,
  parameter bit          STRIP_FCS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mii_en,
  input  logic            mii_er,
  input  logic [IN_W-1:0] mii_d,
  output logic            rdy,
  output logic [7:0]      d,
  output logic            last,
  output logic            done,
  output logic            error,
  output logic [2:0]      err_code,
  output logic [15:0]     frame_len
);

  // With STRIP_FCS the four newest bytes are always held back, so they are never emitted
  // once the frame turns out to have ended.
  localparam int unsigned HOLD    = STRIP_FCS ? 5 : 1;
  localparam logic [2:0]  HOLD_N  = 3'(HOLD);
  localparam logic [16:0] MAX_L   = 17'(MAX_LEN);
  localparam logic [16:0] MIN_L   = 17'(MIN_LEN);
  localparam logic [7:0]  PRE_B   = (IN_W == 4) ? 8'h05 : 8'h55;
  localparam logic [7:0]  SFD_B   = (IN_W == 4) ? 8'h0D : 8'hD5;
  localparam logic [IN_W-1:0] PRE_SYM = PRE_B[IN_W-1:0];
  localparam logic [IN_W-1:0] SFD_SYM = SFD_B[IN_W-1:0];
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {StWaitIdle, StIdle, StPre, StData, StDrop} state_e;

  state_e      state_q;
  logic [3:0]  low_q;      // low nibble waiting for its high half (nibble mode)
  logic        phase_q;    // 1 = a low nibble is held
  logic [15:0] len_q;
  logic [31:0] crc_q;
  logic [7:0]  hold_q [HOLD];
  logic [2:0]  buf_cnt_q;
  logic        er_q;

  logic [7:0]  byte_in;
  logic        byte_cmpl;
  logic        buf_full;
  logic        in_room;
  logic [2:0]  end_code;

  if (IN_W == 4) begin : g_nib
    assign byte_in   = {mii_d, low_q};
    assign byte_cmpl = phase_q;
  end else begin : g_byte
    assign byte_in   = mii_d;
    assign byte_cmpl = 1'b1;
  end

  assign buf_full = (buf_cnt_q == HOLD_N);
  // len_q is the index of the byte now completing, so compare before the increment.
  assign in_room  = ({1'b0, len_q} < MAX_L);

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    end_code = 3'd0;
    if (er_q) begin
      end_code = 3'd5;
    end else if (phase_q) begin
      end_code = 3'd6;
    end else if ({1'b0, len_q} > MAX_L) begin
      end_code = 3'd3;
    end else if ({1'b0, len_q} < MIN_L) begin
      end_code = 3'd2;
    end else if (CHECK_FCS && (crc_q != CRC_RESIDUE)) begin
      end_code = 3'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StWaitIdle;
      rdy       <= 1'b0;
      d         <= 8'h00;
      last      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 3'd0;
      frame_len <= 16'd0;
      low_q     <= 4'h0;
      phase_q   <= 1'b0;
      len_q     <= 16'd0;
      crc_q     <= '1;
      buf_cnt_q <= 3'd0;
      er_q      <= 1'b0;
      for (int i = 0; i < HOLD; i++) hold_q[i] <= 8'h00;
    end else begin
      rdy       <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 3'd0;
      frame_len <= 16'd0;
      case (state_q)
        StWaitIdle: begin
          if (!mii_en) state_q <= StIdle;
        end
        StIdle: begin
          // The first symbol must already be preamble; anything else cannot become valid.
          if (mii_en) state_q <= (mii_d == PRE_SYM) ? StPre : StDrop;
        end
        StPre: begin
          if (!mii_en) begin
            done     <= 1'b1;
            error    <= 1'b1;
            err_code <= 3'd1;
            state_q  <= StIdle;
          end else if (mii_d == SFD_SYM) begin
            state_q   <= StData;
            phase_q   <= 1'b0;
            len_q     <= 16'd0;
            crc_q     <= '1;
            buf_cnt_q <= 3'd0;
            er_q      <= 1'b0;
          end else if (mii_d != PRE_SYM) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          if (!mii_en) begin
            done     <= 1'b1;
            error    <= 1'b1;
            err_code <= 3'd1;
            state_q  <= StIdle;
          end
        end
        StData: begin
          if (!mii_en) begin
            state_q   <= StIdle;
            done      <= 1'b1;
            error     <= (end_code != 3'd0);
            err_code  <= end_code;
            frame_len <= len_q;
            if (buf_full) begin
              rdy  <= 1'b1;
              last <= 1'b1;
              d    <= hold_q[0];
            end
          end else begin
            if (mii_er) er_q <= 1'b1;
            low_q <= mii_d[3:0];
            if (IN_W == 4) phase_q <= ~phase_q;
            if (byte_cmpl) begin
              if (len_q != 16'hFFFF) len_q <= len_q + 16'd1;
              crc_q <= crc32_byte(crc_q, byte_in);
              if (in_room) begin
                if (buf_full) begin
                  rdy <= 1'b1;
                  d   <= hold_q[0];
                end else begin
                  buf_cnt_q <= buf_cnt_q + 3'd1;
                end
                // Newest byte enters at the top; once full, index 0 is the oldest.
                for (int i = 0; i < HOLD - 1; i++) hold_q[i] <= hold_q[i+1];
                hold_q[HOLD-1] <= byte_in;
              end
            end
          end
        end
        default: state_q <= StWaitIdle;
      endcase
    end
  end

endmodule
